cpu_run_ctrl: RTL and testbench

Sequences the CPU on the Nano 9k board. It holds the CPU in reset while the UART loader fills instruction ROM, then releases it into free-run or single-step mode. The CPU advances on a one-cycle clock-enable pulse (cpu_tick) in the board clock domain, which replaces the fabric-divided clock. Sits in the board top between the buttons, the UART loader's load-complete flag, and the CPU's reset and enable inputs.

---
 rtl/cpu_run_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: holds the CPU in reset while the ROM loads, then sequences
// it through free-run and single-step modes with a one-cycle clock enable.
module cpu_run_ctrl #(
  parameter int unsigned DIV         = 5000000,
  parameter int unsigned DEBOUNCE    = 100000,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_done,
  input  logic        btn_mode,
  input  logic        btn_step,
  output logic        cpu_reset,
  output logic        cpu_tick,
  output logic [1:0]  state,
  output logic [31:0] tick_count
);

  localparam int unsigned DIV_W  = $clog2(DIV);
  localparam int unsigned DB_W   = $clog2(DEBOUNCE + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned NBTN   = 2;
  localparam int unsigned BTN_MODE = 0;
  localparam int unsigned BTN_STEP = 1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  logic              ld_s1_q, ld_s2_q;
  logic [NBTN-1:0]   btn_raw;
  logic [NBTN-1:0]   btn_s1_q, btn_s2_q;
  logic [NBTN-1:0]   db_q, db_d;
  logic [NBTN-1:0]   press_q, press_d;
  logic [DB_W-1:0]   db_cnt_q [NBTN];
  logic [DB_W-1:0]   db_cnt_d [NBTN];

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cpu_tick_q, cpu_tick_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic [31:0]       tick_count_q, tick_count_d;

  assign btn_raw = {btn_step, btn_mode};

  // Two-flop synchronisers; buttons idle released (1), load_done idles low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_s1_q  <= 1'b0;
      ld_s2_q  <= 1'b0;
      btn_s1_q <= '1;
      btn_s2_q <= '1;
    end else begin
      ld_s1_q  <= load_done;
      ld_s2_q  <= ld_s1_q;
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
    end
  end

  // Debounce: a level must differ from the accepted level for DEBOUNCE
  // consecutive cycles before it is taken; an accepted press emits one pulse.
  always_comb begin
    for (int i = 0; i < int'(NBTN); i++) begin
      db_cnt_d[i] = '0;
      db_d[i]     = db_q[i];
      press_d[i]  = 1'b0;
      if (btn_s2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE - 1)) begin
          db_d[i]    = btn_s2_q[i];
          press_d[i] = ~btn_s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_q    <= '1;
      press_q <= '0;
      for (int i = 0; i < int'(NBTN); i++) db_cnt_q[i] <= '0;
    end else begin
      db_q    <= db_d;
      press_q <= press_d;
      for (int i = 0; i < int'(NBTN); i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Run-control next state; losing load_done always wins and kills any tick.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    div_d        = div_q;
    cpu_tick_d   = 1'b0;
    tick_count_d = tick_count_q;
    cpu_reset_d  = 1'b1;

    case (state_q)
      ST_LOAD: begin
        if (ld_s2_q) begin
          state_d      = ST_HOLD;
          hold_cnt_d   = '0;
          tick_count_d = '0;
        end
      end
      ST_HOLD: begin
        if (!ld_s2_q) begin
          state_d = ST_LOAD;
        end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (!ld_s2_q) begin
          state_d = ST_LOAD;
        end else begin
          cpu_tick_d = (div_q == DIV_W'(DIV - 1));
          div_d      = cpu_tick_d ? '0 : div_q + DIV_W'(1);
          if (press_q[BTN_MODE]) begin
            state_d = ST_HALT;
            div_d   = '0;
          end
        end
      end
      ST_HALT: begin
        if (!ld_s2_q) begin
          state_d = ST_LOAD;
        end else begin
          cpu_tick_d = press_q[BTN_STEP];
          if (press_q[BTN_MODE]) begin
            state_d = ST_RUN;
            div_d   = '0;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    if (cpu_tick_d) tick_count_d = tick_count_q + 32'd1;
    cpu_reset_d = (state_d == ST_LOAD) || (state_d == ST_HOLD);
  end

  // Run-control state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      hold_cnt_q   <= '0;
      div_q        <= '0;
      cpu_tick_q   <= 1'b0;
      cpu_reset_q  <= 1'b1;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      div_q        <= div_d;
      cpu_tick_q   <= cpu_tick_d;
      cpu_reset_q  <= cpu_reset_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign state      = state_q;
  assign cpu_reset  = cpu_reset_q;
  assign cpu_tick   = cpu_tick_q;
  assign tick_count = tick_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DIV=4, DEBOUNCE=3, HOLD_CYCLES=2.
module tb_cpu_run_ctrl;

  localparam int unsigned DIV         = 4;
  localparam int unsigned DEBOUNCE    = 3;
  localparam int unsigned HOLD_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_done;
  logic        btn_mode;
  logic        btn_step;
  logic        cpu_reset;
  logic        cpu_tick;
  logic [1:0]  state;
  logic [31:0] tick_count;

  int checks    = 0;
  int errors    = 0;
  int tick_seen = 0;
  int t0        = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .DIV         (DIV),
    .DEBOUNCE    (DEBOUNCE),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_done  (load_done),
    .btn_mode   (btn_mode),
    .btn_step   (btn_step),
    .cpu_reset  (cpu_reset),
    .cpu_tick   (cpu_tick),
    .state      (state),
    .tick_count (tick_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge; count ticks and check
  // that no tick coincides with CPU reset.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (cpu_tick === 1'b1) begin
        tick_seen++;
        chk("tick_vs_reset", 32'(cpu_reset), 32'd0);
      end
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int bound, input string tag);
    int n;
    n = 0;
    while (state !== s && n < bound) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic hold_btn(input int which, input int n);
    if (which == 0) btn_mode = 1'b0;
    else            btn_step = 1'b0;
    cyc(n);
    btn_mode = 1'b1;
    btn_step = 1'b1;
  endtask

  task automatic run_gap_then_tick(input logic [31:0] exp_count);
    for (int j = 0; j < 3; j++) begin
      cyc(1);
      chk("run_gap", 32'(cpu_tick), 32'd0);
    end
    cyc(1);
    chk("run_tick", 32'(cpu_tick), 32'd1);
    chk("run_count", tick_count, exp_count);
  endtask

  initial begin
    reset     = 1'b0;
    load_done = 1'b0;
    btn_mode  = 1'b1;
    btn_step  = 1'b1;
    cyc(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_tick", 32'(cpu_tick), 32'd0);
    chk("rst_count", tick_count, 32'd0);

    // Idle in LOAD with no ROM.
    reset = 1'b1;
    cyc(20);
    chk("load_state", 32'(state), 32'd0);
    chk("load_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("load_no_tick", 32'(tick_seen), 32'd0);

    // LOAD -> HOLD (2 cycles) -> RUN, then ticks every DIV cycles.
    load_done = 1'b1;
    wait_state(2'd1, 6, "enter_hold");
    chk("hold_cpu_reset", 32'(cpu_reset), 32'd1);
    cyc(1);
    chk("hold_len", 32'(state), 32'd1);
    cyc(1);
    chk("enter_run", 32'(state), 32'd2);
    chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("run_count0", tick_count, 32'd0);
    for (int k = 1; k <= 5; k++) run_gap_then_tick(32'(k));

    // Mode held 10 cycles: one tick still due before HALT, then none.
    btn_mode = 1'b0;
    wait_state(2'd3, 12, "halt_entry");
    chk("halt_count", tick_count, 32'd6);
    cyc(4);
    btn_mode = 1'b1;
    t0 = tick_seen;
    cyc(12);
    chk("halt_stay", 32'(state), 32'd3);
    chk("halt_no_tick", 32'(tick_seen - t0), 32'd0);

    // Three clean step presses -> three single ticks.
    t0 = tick_seen;
    for (int k = 0; k < 3; k++) begin
      hold_btn(1, 5);
      cyc(8);
    end
    chk("step3_ticks", 32'(tick_seen - t0), 32'd3);
    chk("step3_count", tick_count, 32'd9);
    chk("step3_state", 32'(state), 32'd3);

    // Bouncing step button is rejected; a long hold gives exactly one tick.
    t0 = tick_seen;
    for (int i = 0; i < 6; i++) begin
      btn_step = 1'(i % 2);
      cyc(1);
    end
    btn_step = 1'b1;
    cyc(10);
    chk("bounce_no_tick", 32'(tick_seen - t0), 32'd0);
    hold_btn(1, 50);
    cyc(10);
    chk("long_hold_ticks", 32'(tick_seen - t0), 32'd1);
    chk("long_hold_count", tick_count, 32'd10);

    // Back to RUN, then drop load_done just before a due tick.
    hold_btn(0, 5);
    wait_state(2'd2, 12, "resume_run");
    chk("resume_count", tick_count, 32'd10);
    run_gap_then_tick(32'd11);
    run_gap_then_tick(32'd12);
    cyc(1);
    load_done = 1'b0;
    cyc(3);
    chk("drop_state", 32'(state), 32'd0);
    chk("drop_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("drop_tick_cancel", 32'(cpu_tick), 32'd0);
    chk("drop_count", tick_count, 32'd12);
    t0 = tick_seen;
    cyc(10);
    chk("drop_no_tick", 32'(tick_seen - t0), 32'd0);
    chk("drop_count_hold", tick_count, 32'd12);

    // Reload restarts tick_count.
    load_done = 1'b1;
    wait_state(2'd1, 6, "reload_hold");
    chk("reload_count0", tick_count, 32'd0);
    wait_state(2'd2, 4, "reload_run");
    chk("reload_cpu_reset", 32'(cpu_reset), 32'd0);
    run_gap_then_tick(32'd1);

    // Asynchronous reset during HOLD.
    load_done = 1'b0;
    wait_state(2'd0, 5, "relo_load");
    cyc(2);
    load_done = 1'b1;
    wait_state(2'd1, 6, "hold_again");
    #1 reset = 1'b0;
    #1;
    chk("rst_hold_state", 32'(state), 32'd0);
    chk("rst_hold_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_hold_tick", 32'(cpu_tick), 32'd0);
    cyc(2);
    reset = 1'b1;
    wait_state(2'd1, 8, "hold_after_rst");
    cyc(1);
    chk("hold_after_rst_len", 32'(state), 32'd1);
    cyc(1);
    chk("run_after_rst", 32'(state), 32'd2);
    run_gap_then_tick(32'd1);

    // Asynchronous reset while a mode press is mid-debounce.
    cyc(2);
    btn_mode = 1'b0;
    cyc(3);
    #1 reset = 1'b0;
    #1;
    chk("rst_db_state", 32'(state), 32'd0);
    chk("rst_db_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_db_tick", 32'(cpu_tick), 32'd0);
    chk("rst_db_count", tick_count, 32'd0);
    btn_mode = 1'b1;
    cyc(2);
    reset = 1'b1;
    wait_state(2'd1, 8, "hold_after_rst2");
    cyc(1);
    cyc(1);
    chk("run_after_rst2", 32'(state), 32'd2);
    run_gap_then_tick(32'd1);
    cyc(10);
    chk("no_spurious_halt", 32'(state), 32'd2);
    chk("final_count", tick_count, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
